// File: rtl/spi_sram_controller_if.sv
// Request-port and SPI pin bundle between the core, the SRAM controller and the SRAM.
interface spi_sram_controller_if #(
  parameter int ADDR_LEN  = 17,
  parameter int WORD_SIZE = 16
);
  logic [ADDR_LEN-1:0]  mem_address;
  logic [WORD_SIZE-1:0] mem_write_value;
  logic                 mem_write_enable;
  logic                 mem_request;
  logic [WORD_SIZE-1:0] mem_read_value;
  logic                 mem_request_complete;
  logic                 mem_busy;
  logic                 sd_cs;
  logic                 sd_si;
  logic                 sd_so;
  logic                 sclk;

  // Core / SRAM side: issues requests and returns MISO.
  modport master (
    output mem_address, mem_write_value, mem_write_enable, mem_request, sd_so,
    input  mem_read_value, mem_request_complete, mem_busy, sd_cs, sd_si, sclk
  );

  // Controller side.
  modport slave (
    input  mem_address, mem_write_value, mem_write_enable, mem_request, sd_so,
    output mem_read_value, mem_request_complete, mem_busy, sd_cs, sd_si, sclk
  );
endinterface

// File: rtl/spi_sram_controller.sv
// SPI mode-0 master for serial SRAM: one single-word read or write per request.
// Frame is {cmd, zero-extended address, data}, MSB first, N = 8 + ADDR_FIELD + WORD_SIZE bits.
module spi_sram_controller #(
  parameter int         WORD_SIZE  = 16,
  parameter int         ADDR_LEN   = 17,
  parameter int         ADDR_FIELD = 24,
  parameter int         CLK_DIV    = 2,
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter logic [7:0] WRITE_CMD  = 8'h02
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  spi_sram_controller_if.slave  bus
);

  localparam int N     = 8 + ADDR_FIELD + WORD_SIZE;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [N-1:0]         shift_q;
  logic [WORD_SIZE-1:0] rx_q;
  logic [WORD_SIZE-1:0] read_q;
  logic [DIV_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_q;
  logic                 sclk_q;
  logic                 we_q;

  logic                  start;
  logic                  tick;
  logic                  last_fall;
  logic [ADDR_FIELD-1:0] addr_ext;
  logic [N-1:0]          frame;

  // Acceptance, divider wrap and final falling edge; frame built from the live request operands.
  always_comb begin
    start     = (state == IDLE) && ena && bus.mem_request;
    tick      = (div_q == DIV_W'(CLK_DIV - 1));
    last_fall = (state == SHIFT) && tick && sclk_q && (bit_q == BIT_W'(N - 1));
    addr_ext  = ADDR_FIELD'(bus.mem_address);
    frame     = {(bus.mem_write_enable ? WRITE_CMD : READ_CMD), addr_ext,
                 (bus.mem_write_enable ? bus.mem_write_value : {WORD_SIZE{1'b0}})};
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: losing ena anywhere outside IDLE abandons the frame without a done pulse.
  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.mem_request) state_nxt = SHIFT;
        SHIFT:   if (last_fall)       state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift engine: latch operands at acceptance, sample MISO on sclk rise, advance MOSI on sclk fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      rx_q    <= '0;
      read_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      we_q    <= 1'b0;
    end else if (start) begin
      shift_q <= frame;
      we_q    <= bus.mem_write_enable;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
    end else if (state == SHIFT && ena) begin
      if (tick) begin
        div_q  <= '0;
        sclk_q <= ~sclk_q;
        if (!sclk_q) begin
          rx_q <= WORD_SIZE'({rx_q, bus.sd_so});
        end else begin
          shift_q <= shift_q << 1;
          bit_q   <= bit_q + 1'b1;
          if (last_fall && !we_q) read_q <= rx_q;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end else begin
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
    end
  end

  // Pin and status outputs decoded from state; MOSI is forced low outside the shift phase.
  always_comb begin
    bus.sd_cs                = (state != SHIFT);
    bus.mem_busy             = (state == SHIFT);
    bus.mem_request_complete = (state == DONE);
    bus.sclk                 = sclk_q;
    bus.sd_si                = (state == SHIFT) ? shift_q[N-1] : 1'b0;
    bus.mem_read_value       = read_q;
  end

endmodule
